alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised two-stage pipelined ALU for one VLIW issue slot.
- Successor to the 2-bit-op combinational ALU: generalised data width, 3-bit opcode, full flag set (Z/N/C/V), valid/ready handshake with backpressure.
- Sits between operand read and writeback. One instance per slot.

Parameters:
- W, 32, datapath width in bits; minimum 8, must be a power of two.
- SHW, $clog2(W), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/op bundle valid
- in_ready  out  1  block accepts the bundle this cycle
- op  in  3  opcode (see Behaviour)
- in1  in  W  operand A
- in2  in  W  operand B; low SHW bits are the shift amount for shifts
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result this cycle
- ans  out  W  result
- flags  out  4  {V,C,N,Z}
- err  out  1  illegal/disabled opcode was executed

Behaviour:
- Opcodes:
  - 0 ADD: in1+in2.
  - 1 AND.
  - 2 SRA: arithmetic right shift; in1 is signed, shift amount is in2[SHW-1:0].
  - 3 ZERO: result 0.
  - 4 SUB: in1-in2.
  - 5 OR.
  - 6 XOR.
  - 7 MUL: see Optional Feature.
- Stage 1 (S1) registers op/in1/in2 on an input handshake (in_valid && in_ready).
- Stage 2 (S2) registers ans/flags/err, computed combinationally from S1.
- Latency: exactly 2 cycles from the input handshake to out_valid with no stall. Throughput: 1 per cycle.
- Advance rules:
  - s2_adv = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || s2_adv (combinational; no dependency on in_valid)
- Stall: while out_valid && !out_ready, ans/flags/err hold stable and S1 holds. in_ready stays 1 until S1 fills.
- Simultaneous events: a cycle with output consumed, S1 moving to S2 and a new input accepted is legal and loses nothing.
- Zero flag: Z = (result == 0). It is recomputed for every op, including ZERO (Z=1); no sticky value.
- Negative flag: N = result[W-1].
- Carry flag C:
  - ADD: carry out of bit W-1.
  - SUB: not-borrow, i.e. 1 when in1 >= in2 unsigned.
  - All other ops: 0.
- Overflow flag V: signed overflow for ADD/SUB; 0 otherwise.
- Shifts: shift amount is taken modulo W; shifting by 0 returns in1.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - s1_valid=0, out_valid=0, ans=0, flags=4'b0000, err=0.
  - in_ready reads 1 during reset.
  - Any in-flight bundle is discarded when reset asserts mid-operation.
- Data registers update only on their stage handshake. Holding is not gated by out_ready alone.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: op 7 = MUL, low W bits of the unsigned product in1*in2.
  - Computed in S2 from registered operands; latency unchanged.
  - Z and N from the result; C and V are 0; err=0.
- Undefined: op 7 is illegal. Result 0, Z=1, err=1, and the bundle still flows through the pipeline normally.

Decomposition:
- Package alu_pkg holds:
  - op encoding localparams OP_ADD..OP_MUL (3 bits);
  - flag bit indices FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3;
  - FLAG_W=4.
- One natural sub-module: alu_core, purely combinational (op, a, b -> result, flags, err), instantiated between S1 and S2.
- Handshake and registers stay in alu_pipe.

Test Plan:
- Reset then idle: rst_n low mid-stream with 2 bundles in flight -> after release out_valid=0, ans=0, flags=0, in_ready=1; no stale result appears.
- ADD, W=32: 0xFFFFFFFF+1 -> 2 cycles later ans=0, flags Z=1, C=1, V=0, N=0. Then 0x7FFFFFFF+1 -> ans=0x80000000, V=1, N=1, Z=0.
- SUB and SRA: 5-7 -> ans=0xFFFFFFFE, N=1, C=0. SRA 0x80000000 by 4 -> 0xF8000000. SRA by in2=0x21 -> shift 1, result 0xC0000000.
- Streaming with backpressure: 6 back-to-back ADDs, with out_ready low for cycles 3-5 -> in_ready drops once S1 is full, ans holds steady, all 6 results emerge in order with no duplicates.
- Flag non-stickiness: ZERO op followed by AND 0xF0&0x30 -> first Z=1, second ans=0x30, Z=0.
- Op 7 with a=0x10000, b=0x10000: with ALU_PIPE_MUL_EN -> ans=0, Z=1, err=0; with 3*4 -> ans=12. Without the macro -> ans=0, Z=1, err=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag-vector layout for the pipelined ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_SRA  = 3'd2;
    localparam logic [2:0] OP_ZERO = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    localparam int FLAG_W = 4;
    localparam int FLG_Z  = 0;
    localparam int FLG_N  = 1;
    localparam int FLG_C  = 2;
    localparam int FLG_V  = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: op/a/b -> result, {V,C,N,Z}, err. MUL only when ALU_PIPE_MUL_EN.
// Latency: none (pure combinational). Backpressure: not applicable.
// Without ALU_PIPE_MUL_EN, op 7 yields result 0 with err set.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]        op,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic [W-1:0]      result,
    output logic [FLAG_W-1:0] flags,
    output logic              err
);

    localparam int SHW = $clog2(W);

    logic [W:0] sum;
    logic [W:0] diff;
    logic       c;
    logic       v;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[W-1:0];
                c      = sum[W];
                v      = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                // The extra top bit of diff is the borrow; C is its inverse.
                result = diff[W-1:0];
                c      = ~diff[W];
                v      = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SRA:  result = $signed(a) >>> b[SHW-1:0];
            OP_ZERO: result = '0;
            OP_MUL: begin
`ifdef ALU_PIPE_MUL_EN
                result = a * b;
`else
                err    = 1'b1;
`endif
            end
            default: result = '0;
        endcase
        flags        = '0;
        flags[FLG_Z] = (result == '0);
        flags[FLG_N] = result[W-1];
        flags[FLG_C] = c;
        flags[FLG_V] = v;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU for one VLIW slot (S1 operand regs, S2 result regs); MUL via ALU_PIPE_MUL_EN.
// Latency: 2 cycles from input handshake to out_valid; throughput 1 per cycle.
// Backpressure: out_ready low freezes S2; S1 holds once full and in_ready drops.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [W-1:0]      in1,
    input  logic [W-1:0]      in2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      ans,
    output logic [FLAG_W-1:0] flags,
    output logic              err
);

    logic              s1_valid;
    logic [2:0]        s1_op;
    logic [W-1:0]      s1_a;
    logic [W-1:0]      s1_b;
    logic              s2_adv;
    logic              in_fire;
    logic [W-1:0]      core_result;
    logic [FLAG_W-1:0] core_flags;
    logic              core_err;

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_op    <= op;
                s1_a     <= in1;
                s1_b     <= in2;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    alu_core #(.W(W)) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .result (core_result),
        .flags  (core_flags),
        .err    (core_err)
    );

    // Result registers move only when S1 hands over; a consumed-but-not-refilled slot just drops valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ans       <= '0;
            flags     <= '0;
            err       <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= 1'b1;
                ans       <= core_result;
                flags     <= core_flags;
                err       <= core_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed checks of alu_pipe against a queue-based arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [31:0] ans;
        logic [3:0]  flags;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ans;
    logic [3:0]  flags;
    logic        err;

    int   tests = 0;
    int   fails = 0;
    int   pops = 0;
    res_t exp_q[$];
    logic prev_stall = 1'b0;
    res_t prev_res;
    bit   rnd_done = 1'b0;
    logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h21};

    always #5 clk = ~clk;

    alu_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ans       (ans),
        .flags     (flags),
        .err       (err)
    );

    function automatic res_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint sa, sb, sr;
        longint unsigned ua, ub;
        int sh;
        r  = '0;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b % 32);
        case (o)
            OP_ADD: begin
                r.ans      = a + b;
                sr         = sa + sb;
                r.flags[2] = (ua + ub) > 64'hFFFFFFFF;
                r.flags[3] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_SUB: begin
                r.ans      = a - b;
                sr         = sa - sb;
                r.flags[2] = (ua >= ub);
                r.flags[3] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_AND:  r.ans = a & b;
            OP_OR:   r.ans = a | b;
            OP_XOR:  r.ans = a ^ b;
            OP_SRA:  r.ans = 32'(sa >>> sh);
            OP_ZERO: r.ans = '0;
            default: begin
`ifdef ALU_PIPE_MUL_EN
                r.ans = 32'(ua * ub);
`else
                r.ans = '0;
                r.err = 1'b1;
`endif
            end
        endcase
        r.flags[0] = (r.ans == 32'h0);
        r.flags[1] = r.ans[31];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Record the expected result of every accepted bundle.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready)
            exp_q.push_back(model(op, in1, in2));
    end

    // Compare every consumed result, and check stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {27'h0, out_valid, ans, flags, err}, {27'h0, 1'b1, prev_res});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got ans=%h flags=%b err=%b with nothing outstanding", ans, flags, err);
                end else begin
                    chk("result", {27'h0, ans, flags, err}, {27'h0, exp_q.pop_front()});
                end
                pops++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = {ans, flags, err};
        end
    end

    // Caller is at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        op  = o;
        in1 = a;
        in2 = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        tests++;
        fails++;
        $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected 1");
    endtask

    task automatic directed(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ea, input logic [3:0] ef, input logic ee);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op  = o;
        in1 = a;
        in2 = b;
        @(negedge clk);
        chk({name, "_rdy"}, 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk({name, "_lat"}, 64'(n), 64'd2);
        chk({name, "_ans"}, 64'(ans), 64'(ea));
        chk({name, "_flags"}, 64'(flags), 64'(ef));
        chk({name, "_err"}, 64'(err), 64'(ee));
    endtask

    function automatic logic [31:0] rand_val();
        if ($urandom_range(0, 2) == 0)
            return edge_vals[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 1ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        int vcount;
        int p0;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_state", {26'h0, out_valid, in_ready, ans, flags, err}, {26'h0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0});

        // Reset mid-stream with two bundles in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(OP_ADD, 32'd10, 32'd20);
        send(OP_XOR, 32'hFF, 32'h0F);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'h1);
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_state", {26'h0, out_valid, in_ready, ans, flags, err}, {26'h0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0});
        vcount = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("no_stale_result", 64'(vcount), 64'h0);

        // Hand-computed expectations
        directed("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0101, 1'b0);
        directed("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1010, 1'b0);
        directed("sub_neg", OP_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b0010, 1'b0);
        directed("sub_pos", OP_SUB, 32'd7, 32'd5, 32'h2, 4'b0100, 1'b0);
        directed("sra_4", OP_SRA, 32'h80000000, 32'd4, 32'hF8000000, 4'b0010, 1'b0);
        directed("sra_mod", OP_SRA, 32'h80000000, 32'h21, 32'hC0000000, 4'b0010, 1'b0);
        directed("sra_0", OP_SRA, 32'h12345678, 32'h20, 32'h12345678, 4'b0000, 1'b0);
        directed("zero", OP_ZERO, 32'h1234, 32'h5678, 32'h0, 4'b0001, 1'b0);
        directed("and_nz", OP_AND, 32'hF0, 32'h30, 32'h30, 4'b0000, 1'b0);
`ifdef ALU_PIPE_MUL_EN
        directed("mul_wrap", OP_MUL, 32'h10000, 32'h10000, 32'h0, 4'b0001, 1'b0);
        directed("mul_small", OP_MUL, 32'd3, 32'd4, 32'd12, 4'b0000, 1'b0);
`else
        directed("op7_illegal", OP_MUL, 32'h10000, 32'h10000, 32'h0, 4'b0001, 1'b1);
`endif

        // Streaming with a 3-cycle backpressure window
        @(posedge clk);
        #1;
        p0 = pops;
        drops = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(OP_ADD, 32'(i * 3 + 1), 32'(i + 100));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    if (!in_ready) drops++;
                end
            end
        join
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        chk("bp_in_ready_drop", 64'(drops != 0), 64'h1);
        chk("bp_count", 64'(pops - p0), 64'd6);

        // Randomized traffic with random backpressure
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    send(3'($urandom_range(0, 7)), rand_val(), rand_val());
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
